fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_rd_buf.sv | 56 +++++
 rtl/fifo_reader.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO reader.
// Holds the FSM state encoding, the output buffer depth and the read-issue rule.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int BUF_DEPTH = 3;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [OCC_W:0] ISSUE_MAX = (OCC_W + 1)'(BUF_DEPTH - 1);

    // A new read is safe only if the buffer can absorb it plus any word in flight.
    function automatic logic can_issue(
        input logic [OCC_W-1:0] occ,
        input logic             pend
    );
        logic [OCC_W:0] w_sum;
        w_sum = {1'b0, occ} + {{OCC_W{1'b0}}, pend};
        return (w_sum <= ISSUE_MAX);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// In-order output buffer between the FIFO read port and the consumer.
// Head is always entry 0; a pop shifts the entries down by one.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_pop,
    output logic [OCC_W-1:0]      o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem     [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_nxt [BUF_DEPTH];
    logic [OCC_W-1:0]      r_occ;
    logic [OCC_W-1:0]      w_occ_nxt;
    logic [OCC_W-1:0]      w_wr_idx;

    // With a simultaneous pop the tail slot moves down one, so occ is unchanged.
    always_comb begin
        w_mem_nxt = r_mem;
        w_occ_nxt = r_occ;
        w_wr_idx  = r_occ;
        if (i_pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_wr_idx  = r_occ - OCC_W'(1);
            w_occ_nxt = r_occ - OCC_W'(1);
        end
        if (i_wr) begin
            w_mem_nxt[w_wr_idx] = i_wr_data;
            w_occ_nxt           = w_occ_nxt + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_occ <= w_occ_nxt;
            r_mem <= w_mem_nxt;
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[0];

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a registered-output FIFO and presents them on a
// valid/ready stream, with a run/drain FSM and a pop counter.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read
);

    rd_state_e             r_state;
    rd_state_e             w_state_nxt;
    logic                  r_pend;
    logic [CNT_WIDTH-1:0]  r_words;
    logic [OCC_W-1:0]      w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;

    fifo_rd_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_wr     (r_pend),
        .i_wr_data(fifo_data),
        .i_pop    (w_pop),
        .o_occ    (w_occ),
        .o_head   (w_head)
    );

    // Issue depends only on registered state, never on out_ready.
    assign fifo_rd_en = (r_state == RUN) && !fifo_empty
                        && can_issue(w_occ, r_pend);
    assign out_valid  = (w_occ != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_data   = w_head;
    assign busy       = r_pend || out_valid;
    assign words_read = r_words;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                if (!enable) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    w_state_nxt = RUN;
                end else if (!r_pend && (w_occ == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= fifo_rd_en;
            if (fifo_rd_en) r_words <= r_words + CNT_WIDTH'(1);
        end
    end

endmodule
